// File: rtl/mem_ctrl_if.sv
// Bundles the fetch, load/store and byte-wide RAM signals of mem_ctrl.
// slave = controller side, master = CPU/RAM side.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              rdy;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_done_o;
  logic [31:0]       if_inst_o;
  logic              mm_req_i;
  logic              mm_we_i;
  logic [1:0]        mm_size_i;
  logic [ADDR_W-1:0] mm_addr_i;
  logic [31:0]       mm_wdata_i;
  logic              mm_done_o;
  logic [31:0]       mm_rdata_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic [7:0]        mem_dout_o;
  logic              mem_wr_o;
  logic [7:0]        mem_din_i;

  modport slave (
    input  rdy,
    input  if_req_i, if_addr_i,
    output if_done_o, if_inst_o,
    input  mm_req_i, mm_we_i, mm_size_i, mm_addr_i, mm_wdata_i,
    output mm_done_o, mm_rdata_o,
    output mem_a_o, mem_dout_o, mem_wr_o,
    input  mem_din_i
  );

  modport master (
    output rdy,
    output if_req_i, if_addr_i,
    input  if_done_o, if_inst_o,
    output mm_req_i, mm_we_i, mm_size_i, mm_addr_i, mm_wdata_i,
    input  mm_done_o, mm_rdata_o,
    input  mem_a_o, mem_dout_o, mem_wr_o,
    output mem_din_i
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating instruction fetch against load/store.
// Define MEM_CTRL_RR_ARB_EN for round-robin arbitration; default is fixed MEM priority.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input logic      dclk,
  input logic      rst,
  mem_ctrl_if.slave bus
);

  if (RD_LAT != 1) begin : g_bad_rd_lat
    $error("mem_ctrl: only RD_LAT = 1 is supported");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              who_mm_q, who_mm_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic [23:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d;

  logic              gnt_mm;
  logic [2:0]        cnt_inc;
  logic [2:0]        mm_n;
  logic [ADDR_W-1:0] pause_a;

`ifdef MEM_CTRL_RR_ARB_EN
  logic last_mm_q, last_mm_d;
  // On a tie the requester not granted last wins.
  assign gnt_mm = bus.mm_req_i & (~bus.if_req_i | ~last_mm_q);
`else
  assign gnt_mm = bus.mm_req_i;
`endif

  assign cnt_inc = cnt_q + 3'd1;
  assign pause_a = base_q + ADDR_W'(cnt_q);

  always_comb begin
    unique case (bus.mm_size_i)
      2'b00:   mm_n = 3'd1;
      2'b01:   mm_n = 3'd2;
      default: mm_n = 3'd4;
    endcase
  end

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves a latch.
    state_d  = state_q;
    who_mm_d = who_mm_q;
    base_d   = base_q;
    mem_a_d  = mem_a_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    inst_d   = inst_q;
    rdata_d  = rdata_q;
    dout_d   = dout_q;
    wr_d     = wr_q;
`ifdef MEM_CTRL_RR_ARB_EN
    last_mm_d = last_mm_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.rdy && (bus.mm_req_i || bus.if_req_i)) begin
          who_mm_d = gnt_mm;
          base_d   = gnt_mm ? bus.mm_addr_i : bus.if_addr_i;
          mem_a_d  = base_d;
          n_d      = gnt_mm ? mm_n : 3'd4;
          cnt_d    = 3'd0;
          vld_d    = 1'b0;
          buf_d    = 32'h0;
          wdata_d  = bus.mm_wdata_i[31:8];
          dout_d   = bus.mm_wdata_i[7:0];
          wr_d     = gnt_mm & bus.mm_we_i;
          state_d  = (gnt_mm && bus.mm_we_i) ? S_WR : S_RD;
`ifdef MEM_CTRL_RR_ARB_EN
          last_mm_d = gnt_mm;
`endif
        end
      end

      S_RD: begin
        if (bus.rdy) begin
          mem_a_d = mem_a_q + ADDR_W'(1);
          vld_d   = 1'b1;
          // vld_q marks mem_din_i as the answer to last cycle's live address.
          if (vld_q) begin
            buf_d = buf_q | ({24'h0, bus.mem_din_i} << {cnt_q[1:0], 3'b000});
            cnt_d = cnt_inc;
            if (cnt_inc == n_q) begin
              state_d = S_DONE;
              if (who_mm_q) rdata_d = buf_d;
              else          inst_d  = buf_d;
            end
          end
        end else begin
          vld_d   = 1'b0;
          mem_a_d = pause_a;
        end
      end

      S_WR: begin
        if (bus.rdy) begin
          cnt_d = cnt_inc;
          if (cnt_inc == n_q) begin
            state_d = S_DONE;
            wr_d    = 1'b0;
          end else begin
            mem_a_d = mem_a_q + ADDR_W'(1);
            dout_d  = wdata_q[7:0];
            wdata_d = {8'h00, wdata_q[23:8]};
          end
        end
      end

      S_DONE: begin
        if (bus.rdy) state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge dclk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      who_mm_q <= 1'b0;
      base_q   <= '0;
      mem_a_q  <= '0;
      n_q      <= 3'd0;
      cnt_q    <= 3'd0;
      vld_q    <= 1'b0;
      wdata_q  <= 24'h0;
      buf_q    <= 32'h0;
      inst_q   <= 32'h0;
      rdata_q  <= 32'h0;
      dout_q   <= 8'h0;
      wr_q     <= 1'b0;
`ifdef MEM_CTRL_RR_ARB_EN
      last_mm_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      who_mm_q <= who_mm_d;
      base_q   <= base_d;
      mem_a_q  <= mem_a_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      inst_q   <= inst_d;
      rdata_q  <= rdata_d;
      dout_q   <= dout_d;
      wr_q     <= wr_d;
`ifdef MEM_CTRL_RR_ARB_EN
      last_mm_q <= last_mm_d;
`endif
    end
  end

  // Pause and reset gate the strobes immediately so no stray write or done escapes.
  assign bus.mem_a_o    = (state_q == S_RD && !bus.rdy) ? pause_a : mem_a_q;
  assign bus.mem_dout_o = dout_q;
  assign bus.mem_wr_o   = wr_q & bus.rdy & ~rst;
  assign bus.if_done_o  = (state_q == S_DONE) & ~who_mm_q & bus.rdy & ~rst;
  assign bus.mm_done_o  = (state_q == S_DONE) &  who_mm_q & bus.rdy & ~rst;
  assign bus.if_inst_o  = inst_q;
  assign bus.mm_rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus queues expected results, a negedge
// monitor checks done pulses, returned data and per-cycle RAM bus activity.
module tb_mem_ctrl;
  logic dclk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 dclk = ~dclk;
  always @(posedge dclk) cyc <= cyc + 1;

  mem_ctrl_if #(.ADDR_W(32)) bus ();
  mem_ctrl #(.ADDR_W(32), .RD_LAT(1)) dut (.dclk(dclk), .rst(rst), .bus(bus));

  // Byte RAM model, one-cycle read latency; the bench preloads it via poke.
  logic [7:0]  ram [0:4095];
  logic        poke_en = 1'b0;
  logic [11:0] poke_a  = 12'h0;
  logic [7:0]  poke_d  = 8'h0;
  always @(posedge dclk) begin
    if (poke_en)           ram[poke_a] <= poke_d;
    else if (bus.mem_wr_o) ram[bus.mem_a_o[11:0]] <= bus.mem_dout_o;
    bus.mem_din_i <= ram[bus.mem_a_o[11:0]];
  end

  typedef struct { int due; logic chk; logic [31:0] data; } exp_t;
  typedef struct { int cyc; logic chk_a; logic [31:0] a; logic chk_d; logic [7:0] d; logic wr; } bus_t;
  exp_t if_q[$];
  exp_t mm_q[$];
  bus_t bus_q[$];
  exp_t mon_e;
  bus_t mon_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_bus(input int cy, input logic chk_a, input logic [31:0] a,
                         input logic chk_d, input logic [7:0] d, input logic wr);
    bus_q.push_back('{cyc: cy, chk_a: chk_a, a: a, chk_d: chk_d, d: d, wr: wr});
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    poke_a = a; poke_d = d; poke_en = 1'b1;
    @(posedge dclk); #1;
    poke_en = 1'b0;
  endtask

  // lat = hand-computed cycles from issue (cycle c) to the done cycle.
  task automatic if_op(input logic [31:0] a, input logic [31:0] exp_inst, input int lat);
    bit seen = 1'b0;
    if_q.push_back('{due: cyc + lat, chk: 1'b1, data: exp_inst});
    bus.if_addr_i = a;
    bus.if_req_i  = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge dclk);
      seen = bus.if_done_o;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL if_timeout: no if_done_o for %h within 40 cycles", a);
    end
    bus.if_req_i = 1'b0;
    @(posedge dclk); #1;
  endtask

  task automatic mm_op(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input int lat);
    bit seen = 1'b0;
    mm_q.push_back('{due: cyc + lat, chk: !we, data: exp_rd});
    bus.mm_we_i    = we;
    bus.mm_size_i  = sz;
    bus.mm_addr_i  = a;
    bus.mm_wdata_i = wd;
    bus.mm_req_i   = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge dclk);
      seen = bus.mm_done_o;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL mm_timeout: no mm_done_o for %h within 40 cycles", a);
    end
    bus.mm_req_i = 1'b0;
    @(posedge dclk); #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a result or a bus cycle is due.
  always @(negedge dclk) begin
    if (!rst) begin
      if (bus.if_done_o && bus.mm_done_o) begin
        checks++; errors++;
        $display("FAIL done_onehot: both done pulses high at cycle %0d", cyc);
      end
      if (bus.if_done_o) begin
        if (if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_done_unexpected: pulse at cycle %0d with nothing pending", cyc);
        end else begin
          mon_e = if_q.pop_front();
          check("if_done_cycle", cyc, mon_e.due);
          check("if_inst", bus.if_inst_o, mon_e.data);
        end
      end
      if (bus.mm_done_o) begin
        if (mm_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mm_done_unexpected: pulse at cycle %0d with nothing pending", cyc);
        end else begin
          mon_e = mm_q.pop_front();
          check("mm_done_cycle", cyc, mon_e.due);
          if (mon_e.chk) check("mm_rdata", bus.mm_rdata_o, mon_e.data);
        end
      end
      if (bus_q.size() != 0 && bus_q[0].cyc == cyc) begin
        mon_b = bus_q.pop_front();
        if (mon_b.chk_a) check("mem_a", bus.mem_a_o, mon_b.a);
        if (mon_b.chk_d) check("mem_dout", {24'h0, bus.mem_dout_o}, {24'h0, mon_b.d});
        check("mem_wr", {31'h0, bus.mem_wr_o}, {31'h0, mon_b.wr});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    bus.rdy = 1'b1;
    bus.if_req_i = 1'b0; bus.if_addr_i = 32'h0;
    bus.mm_req_i = 1'b0; bus.mm_we_i = 1'b0; bus.mm_size_i = 2'b00;
    bus.mm_addr_i = 32'h0; bus.mm_wdata_i = 32'h0;
    @(posedge dclk); #1;

    poke(12'h000, 8'h13); poke(12'h001, 8'h00); poke(12'h002, 8'h00); poke(12'h003, 8'h00);
    poke(12'h010, 8'h80);
    poke(12'h200, 8'h11); poke(12'h201, 8'h22); poke(12'h202, 8'h33); poke(12'h203, 8'h44);
    poke(12'h400, 8'h00); poke(12'h401, 8'h00); poke(12'h402, 8'h00); poke(12'h403, 8'h00);
    poke(12'hFFF, 8'h34);

    check("rst_mem_a", bus.mem_a_o, 32'h0);
    check("rst_mem_dout", {24'h0, bus.mem_dout_o}, 32'h0);
    check("rst_mem_wr", {31'h0, bus.mem_wr_o}, 32'h0);
    check("rst_if_done", {31'h0, bus.if_done_o}, 32'h0);
    check("rst_mm_done", {31'h0, bus.mm_done_o}, 32'h0);
    check("rst_if_inst", bus.if_inst_o, 32'h0);
    check("rst_mm_rdata", bus.mm_rdata_o, 32'h0);
    rst = 1'b0;

    // Word fetch at 0: addresses 0..3 in cycles 1-4, done in cycle 6.
    c = cyc;
    for (int k = 1; k <= 4; k++) exp_bus(c + k, 1'b1, 32'(k - 1), 1'b0, 8'h0, 1'b0);
    if_op(32'h0000_0000, 32'h0000_0013, 6);

    // Simultaneous requests: MEM byte load first (cycle 3), IF done 7 cycles later.
    fork
      mm_op(1'b0, 2'b00, 32'h0000_0010, 32'h0, 32'h0000_0080, 3);
      if_op(32'h0000_0200, 32'h4433_2211, 10);
    join

    // Store half 0xBEEF at 0x100.
    c = cyc;
    exp_bus(c + 1, 1'b1, 32'h0000_0100, 1'b1, 8'hEF, 1'b1);
    exp_bus(c + 2, 1'b1, 32'h0000_0101, 1'b1, 8'hBE, 1'b1);
    exp_bus(c + 3, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
    mm_op(1'b1, 2'b01, 32'h0000_0100, 32'h0000_BEEF, 32'h0, 3);
    mm_op(1'b0, 2'b01, 32'h0000_0100, 32'h0, 32'h0000_BEEF, 4);

    // Half load wrapping past the top of the address space.
    poke(12'h000, 8'h12);
    c = cyc;
    exp_bus(c + 1, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'h0, 1'b0);
    exp_bus(c + 2, 1'b1, 32'h0000_0000, 1'b0, 8'h0, 1'b0);
    mm_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0, 32'h0000_1234, 4);

    // Misaligned word store, then word/byte/half loads over it; load data must survive the store.
    mm_op(1'b1, 2'b10, 32'h0000_0301, 32'hDEAD_BEEF, 32'h0, 5);
    check("rdata_hold_after_store", bus.mm_rdata_o, 32'h0000_1234);
    check("inst_hold_after_mm", bus.if_inst_o, 32'h4433_2211);
    mm_op(1'b0, 2'b11, 32'h0000_0301, 32'h0, 32'hDEAD_BEEF, 6);
    mm_op(1'b0, 2'b00, 32'h0000_0302, 32'h0, 32'h0000_00BE, 3);
    mm_op(1'b0, 2'b01, 32'h0000_0303, 32'h0, 32'h0000_DEAD, 4);

    // Fetch with rdy low in cycles 3-5: address holds on byte 1, done slips 4 cycles.
    c = cyc;
    exp_bus(c + 1, 1'b1, 32'h0000_0200, 1'b0, 8'h0, 1'b0);
    exp_bus(c + 2, 1'b1, 32'h0000_0201, 1'b0, 8'h0, 1'b0);
    for (int k = 3; k <= 5; k++) exp_bus(c + k, 1'b1, 32'h0000_0201, 1'b0, 8'h0, 1'b0);
    fork
      if_op(32'h0000_0200, 32'h4433_2211, 10);
      begin
        repeat (3) @(posedge dclk);
        #1 bus.rdy = 1'b0;
        repeat (3) @(posedge dclk);
        #1 bus.rdy = 1'b1;
      end
    join

    // Reset in cycle 2 of a word store: only byte 0 lands, no done, back to IDLE.
    c = cyc;
    exp_bus(c + 1, 1'b1, 32'h0000_0400, 1'b1, 8'hD4, 1'b1);
    bus.mm_we_i = 1'b1; bus.mm_size_i = 2'b10;
    bus.mm_addr_i = 32'h0000_0400; bus.mm_wdata_i = 32'hA1B2_C3D4;
    bus.mm_req_i = 1'b1;
    @(posedge dclk); #1;
    @(posedge dclk); #1;
    rst = 1'b1;
    bus.mm_req_i = 1'b0;
    @(posedge dclk); #1;
    rst = 1'b0;
    check("abort_mem_wr", {31'h0, bus.mem_wr_o}, 32'h0);
    check("abort_mem_a", bus.mem_a_o, 32'h0);
    repeat (8) @(posedge dclk);
    #1;
    check("abort_ram_400", {24'h0, ram[12'h400]}, 32'h0000_00D4);
    check("abort_ram_401", {24'h0, ram[12'h401]}, 32'h0);
    check("abort_ram_402", {24'h0, ram[12'h402]}, 32'h0);
    check("abort_ram_403", {24'h0, ram[12'h403]}, 32'h0);
    if_op(32'h0000_0200, 32'h4433_2211, 6);

    repeat (3) @(posedge dclk);
    #1;
    check("if_queue_drained", if_q.size(), 32'h0);
    check("mm_queue_drained", mm_q.size(), 32'h0);
    check("bus_queue_drained", bus_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the single 8-bit RAM port and the CPU's two requesters: instruction fetch (IF) and load/store (MEM).
- Accepts one word/half/byte request at a time. Serialises it into per-byte RAM cycles and assembles little-endian read data.
- Returns one result with a one-cycle done pulse.
- Arbitrates IF against MEM. The RAM chip-enable logic in cpu stays outside this block.

Parameters:
- ADDR_W, 32, address width; all byte address increments wrap modulo 2^ADDR_W.
- RD_LAT, 1, RAM read latency in cycles; only 1 is supported, and other values are a compile-time error.

Ports:
- dclk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global run enable; 0 = pause
- if_req_i  in  1  fetch request (level); held until if_done_o
- if_addr_i  in  ADDR_W  fetch address; always a 4-byte read
- if_done_o  out  1  one-cycle pulse; if_inst_o valid in the same cycle
- if_inst_o  out  32  fetched word, little-endian
- mm_req_i  in  1  load/store request (level); held until mm_done_o
- mm_we_i  in  1  1 = store, 0 = load
- mm_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word
- mm_addr_i  in  ADDR_W  load/store byte address; misaligned addresses allowed
- mm_wdata_i  in  32  store data; low bytes are used first
- mm_done_o  out  1  one-cycle pulse
- mm_rdata_o  out  32  load data, zero-extended; sign extension is done in MEM
- mem_a_o  out  ADDR_W  RAM address
- mem_dout_o  out  8  RAM write byte
- mem_wr_o  out  1  1 = write, 0 = read
- mem_din_i  in  8  RAM read byte; valid the cycle after its address is driven

Behaviour:
- Reset
  - Synchronous rst=1 sets: state IDLE, byte counter 0, mem_a_o=0, mem_dout_o=0, mem_wr_o=0, both done=0, if_inst_o=0, mm_rdata_o=0.
  - rst mid-transfer abandons the transfer: no done is produced and no further RAM write occurs.
- States
  - IDLE: sample requests.
  - RD: issue addresses and capture bytes.
  - WR: write bytes.
  - DONE: pulse done for one cycle, then return to IDLE.
- Grant (IDLE, rdy=1)
  - If mm_req_i=1, grant MEM; otherwise, if if_req_i=1, grant IF.
  - Latch the granted address, N bytes (IF: 4; MEM: 1, 2 or 4) and the store data.
  - Requests are sampled only in IDLE. Requesters drop req in the cycle after done.
  - The DONE→IDLE cycle gives the one-cycle turnaround.
- Read, N bytes
  - Cycle k=1..N after the grant edge: mem_a_o = addr+(k-1), mem_wr_o=0.
  - Byte k-1 is captured at the end of cycle k+1 into bits [8(k-1)+7 : 8(k-1)].
  - DONE follows in cycle N+2 (word: cycle 6).
  - Unused upper bytes are 0.
  - The rdata/inst output register holds its value until the next read by the same requester.
- Write, N bytes
  - Cycle k=1..N: mem_a_o = addr+(k-1), mem_dout_o = wdata byte k-1, mem_wr_o=1.
  - DONE in cycle N+1.
- Done pulse
  - Exactly one of if_done_o / mm_done_o is high, in the DONE cycle only.
- Pause (rdy=0)
  - State and counters freeze; mem_wr_o is forced 0; no done is issued (a DONE state waits).
  - During a paused read, mem_a_o presents the address of the next byte to be captured.
  - On the first rdy=1 cycle after a pause, nothing is captured (a re-latency cycle), then the sequence continues.
  - A paused write re-drives the current byte on resume.
- Address wrap: addr+k wraps past all-ones to 0 (e.g. 0xFFFFFFFF then 0x00000000).
- Simultaneous IF and MEM requests: MEM wins; IF is served at the next IDLE.

Optional Feature:
- Macro: MEM_CTRL_RR_ARB_EN.
- Defined: round-robin grant. When both requests are pending in IDLE, the requester not granted last wins; a single pending request is always granted. The last-grant flag resets to IF, so MEM wins the first tie.
- Undefined: fixed MEM priority as above; IF can starve under back-to-back MEM traffic.

Test Plan:
- Fetch at 0x00000000, RAM bytes 13 00 00 00 (ascending addresses), rdy=1 → mem_a_o 0,1,2,3 in cycles 1-4; if_done_o=1 and if_inst_o=0x00000013 in cycle 6 only.
- if_req_i and mm_req_i (load byte at 0x10, RAM[0x10]=0x80) raised together → mm_done_o with mm_rdata_o=0x00000080 in cycle 3; IF grant follows, with if_done_o 7 cycles later. With MEM_CTRL_RR_ARB_EN, the second tie after this is won by IF.
- Store half 0xBEEF at 0x100 → cycle 1: mem_a_o=0x100, mem_dout_o=0xEF, mem_wr_o=1; cycle 2: mem_a_o=0x101, mem_dout_o=0xBE; mm_done_o in cycle 3; mem_wr_o=0 otherwise.
- Load half at 0xFFFFFFFF with bytes 34,12 → addresses 0xFFFFFFFF, 0x00000000; mm_rdata_o=0x00001234.
- Word fetch with rdy=0 for 3 cycles after byte 1 is captured → no capture or done during the pause, mem_wr_o=0; result still matches RAM contents, with done delayed by 4 cycles.
- rst=1 in cycle 2 of a word store → mem_wr_o=0 from the next cycle; no mm_done_o; only one RAM byte modified; controller in IDLE.
